// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// tank_pkg : shared tank-game types (directions, block kinds, bullet states)
// Rev 1.0
// ============================================================================
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        EXPLODE = 2'd2
    } bullet_state_e;

    // Tile codes shared with the map renderer
    localparam logic [2:0] BRICK = 3'd0;
    localparam logic [2:0] WALL  = 3'd1;
    localparam logic [2:0] TREE  = 3'd2;
    localparam logic [2:0] WATER = 3'd3;
    localparam logic [2:0] AIR   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/bullet_ctrl_if.sv
`default_nettype none
// ============================================================================
// bullet_ctrl_if : tank/raster/map inputs and sprite/collide outputs of bullet_ctrl
// Rev 1.0
// ============================================================================
interface bullet_ctrl_if #(
    parameter int COLOR_BITS = 24
);
    import tank_pkg::*;

    logic                    fire_i;
    logic [9:0]              tank_x_i;
    logic [9:0]              tank_y_i;
    dir_e                    tank_dir_i;
    logic [9:0]              hpos_i;
    logic [9:0]              vpos_i;
    logic                    display_enable_i;
    logic                    all_hard_block_i;
    logic                    destroyable_block_i;
    logic                    bullet_collide_o;
    logic                    bullet_enable_o;
    logic                    bullet_active_o;
    logic                    exploding_o;
    logic [COLOR_BITS/3-1:0] bullet_blue_o;
    logic [COLOR_BITS/3-1:0] bullet_green_o;
    logic [COLOR_BITS/3-1:0] bullet_red_o;

    modport slave (
        input  fire_i, tank_x_i, tank_y_i, tank_dir_i,
        input  hpos_i, vpos_i, display_enable_i,
        input  all_hard_block_i, destroyable_block_i,
        output bullet_collide_o, bullet_enable_o, bullet_active_o, exploding_o,
        output bullet_blue_o, bullet_green_o, bullet_red_o
    );

    modport master (
        output fire_i, tank_x_i, tank_y_i, tank_dir_i,
        output hpos_i, vpos_i, display_enable_i,
        output all_hard_block_i, destroyable_block_i,
        input  bullet_collide_o, bullet_enable_o, bullet_active_o, exploding_o,
        input  bullet_blue_o, bullet_green_o, bullet_red_o
    );

endinterface
`default_nettype wire

// File: rtl/bullet_spawn_calc.sv
`default_nettype none
// ============================================================================
// bullet_spawn_calc : spawn point in front of the tank, flags off-field spawns
// Rev 1.0
// ============================================================================
module bullet_spawn_calc
    import tank_pkg::*;
#(
    parameter int TANK_SIZE   = 32,
    parameter int BULLET_SIZE = 8
) (
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  dir_e       dir,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y,
    output logic       underflow
);

    localparam logic [9:0] CENTER_OFS = 10'(TANK_SIZE / 2 - BULLET_SIZE / 2);
    localparam logic [9:0] BSZ        = 10'(BULLET_SIZE);
    localparam logic [9:0] TSZ        = 10'(TANK_SIZE);

    always_comb begin
        spawn_x   = tank_x + CENTER_OFS;
        spawn_y   = tank_y + CENTER_OFS;
        underflow = 1'b0;
        case (dir)
            UP: begin
                spawn_y   = tank_y - BSZ;
                underflow = (tank_y < BSZ);
            end
            DOWN: begin
                spawn_y = tank_y + TSZ;
            end
            LEFT: begin
                spawn_x   = tank_x - BSZ;
                underflow = (tank_x < BSZ);
            end
            RIGHT: begin
                spawn_x = tank_x + TSZ;
            end
            default: begin
                underflow = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bullet_ctrl.sv
`default_nettype none
// ============================================================================
// bullet_ctrl : single-bullet engine - spawn, per-frame flight, hit detect, explode
// Rev 1.0
// ============================================================================
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int                    COLOR_BITS     = 24,
    parameter int                    BULLET_SIZE    = 8,
    parameter int                    TANK_SIZE      = 32,
    parameter int                    SPEED          = 4,
    parameter int                    FRAME_TICK_V   = 480,
    parameter int                    EXPLODE_FRAMES = 8,
    parameter logic [COLOR_BITS-1:0] BULLET_RGB     = 24'hFFFFFF
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    bullet_ctrl_if.slave bus
);

    localparam int                CH         = COLOR_BITS / 3;
    localparam int                CNT_W      = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
    localparam logic [10:0]       BOX_LAST   = 11'(BULLET_SIZE - 1);
    localparam logic [9:0]        SPD        = 10'(SPEED);
    localparam logic [9:0]        MOVE_LIMIT = 10'(1023 - BULLET_SIZE - SPEED);
    localparam logic [9:0]        TICK_V     = 10'(FRAME_TICK_V);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(EXPLODE_FRAMES - 1);

    bullet_state_e    state, state_nx;
    dir_e             dir, dir_nx;
    logic [9:0]       bx, by, bx_nx, by_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             fire_pend, hit;
    logic             frame_tick, in_box, hit_now;
    logic [9:0]       spawn_x, spawn_y;
    logic             spawn_uf;
    logic [10:0]      h11, v11, bx11, by11;

    bullet_spawn_calc #(
        .TANK_SIZE   (TANK_SIZE),
        .BULLET_SIZE (BULLET_SIZE)
    ) u_spawn (
        .tank_x    (bus.tank_x_i),
        .tank_y    (bus.tank_y_i),
        .dir       (bus.tank_dir_i),
        .spawn_x   (spawn_x),
        .spawn_y   (spawn_y),
        .underflow (spawn_uf)
    );

    assign frame_tick = (bus.vpos_i == TICK_V) && (bus.hpos_i == 10'd0);

    // 11-bit compare so a box near x/y=1023 does not wrap back to 0
    assign h11    = {1'b0, bus.hpos_i};
    assign v11    = {1'b0, bus.vpos_i};
    assign bx11   = {1'b0, bx};
    assign by11   = {1'b0, by};
    assign in_box = bus.display_enable_i
                 && (h11 >= bx11) && (h11 <= bx11 + BOX_LAST)
                 && (v11 >= by11) && (v11 <= by11 + BOX_LAST);

    assign hit_now = (state == FLY) && in_box && bus.all_hard_block_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            dir       <= UP;
            bx        <= '0;
            by        <= '0;
            cnt       <= '0;
            fire_pend <= 1'b0;
            hit       <= 1'b0;
        end else begin
            state <= state_nx;
            dir   <= dir_nx;
            bx    <= bx_nx;
            by    <= by_nx;
            cnt   <= cnt_nx;
            if ((state == IDLE) && !frame_tick)
                fire_pend <= fire_pend | bus.fire_i;
            else
                fire_pend <= 1'b0;
            if (frame_tick)
                hit <= 1'b0;
            else if (hit_now)
                hit <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        bx_nx    = bx;
        by_nx    = by;
        cnt_nx   = cnt;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (fire_pend && !spawn_uf) begin
                        state_nx = FLY;
                        dir_nx   = bus.tank_dir_i;
                        bx_nx    = spawn_x;
                        by_nx    = spawn_y;
                    end
                end
                FLY: begin
                    // A hit seen on the tick pixel itself still wins over the move
                    if (hit || hit_now) begin
                        state_nx = EXPLODE;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        case (dir)
                            UP:      if (by < SPD)        state_nx = IDLE; else by_nx = by - SPD;
                            DOWN:    if (by > MOVE_LIMIT) state_nx = IDLE; else by_nx = by + SPD;
                            LEFT:    if (bx < SPD)        state_nx = IDLE; else bx_nx = bx - SPD;
                            RIGHT:   if (bx > MOVE_LIMIT) state_nx = IDLE; else bx_nx = bx + SPD;
                            default: state_nx = IDLE;
                        endcase
                    end
                end
                EXPLODE: begin
                    if (cnt == '0)
                        state_nx = IDLE;
                    else
                        cnt_nx = cnt - CNT_W'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.bullet_active_o  = (state == FLY);
    assign bus.exploding_o      = (state == EXPLODE);
    assign bus.bullet_enable_o  = in_box && (state != IDLE);
    assign bus.bullet_collide_o = in_box && bus.destroyable_block_i && (state == FLY);
    assign bus.bullet_blue_o    = bus.bullet_enable_o ? BULLET_RGB[3*CH-1:2*CH] : '0;
    assign bus.bullet_green_o   = bus.bullet_enable_o ? BULLET_RGB[2*CH-1:CH]   : '0;
    assign bus.bullet_red_o     = bus.bullet_enable_o ? BULLET_RGB[CH-1:0]      : '0;

endmodule
`default_nettype wire

// File: tb/tb_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bullet_ctrl : directed spawn table plus flight/hit/explode/reset sequences
// Rev 1.0
// ============================================================================
module tb_bullet_ctrl;
    import tank_pkg::*;

    typedef struct {
        logic [9:0] tx;
        logic [9:0] ty;
        dir_e       dir;
        logic       refused;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    logic clk;
    logic reset_ni;
    int   total;
    int   bad;
    vec_t vecs[8];

    bullet_ctrl_if #(.COLOR_BITS(24)) bi();

    bullet_ctrl dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        bi.hpos_i              = 10'd1023;
        bi.vpos_i              = 10'd1023;
        bi.display_enable_i    = 1'b0;
        bi.all_hard_block_i    = 1'b0;
        bi.destroyable_block_i = 1'b0;
    endtask

    task automatic drive_pix(input logic [9:0] h, input logic [9:0] v, input logic de,
                             input logic hard, input logic destr);
        bi.hpos_i              = h;
        bi.vpos_i              = v;
        bi.display_enable_i    = de;
        bi.all_hard_block_i    = hard;
        bi.destroyable_block_i = destr;
        #1;
    endtask

    task automatic frame();
        bi.vpos_i              = 10'd480;
        bi.hpos_i              = 10'd0;
        bi.display_enable_i    = 1'b0;
        bi.all_hard_block_i    = 1'b0;
        bi.destroyable_block_i = 1'b0;
        step();
        park();
        #1;
    endtask

    task automatic fire_pulse();
        bi.fire_i = 1'b1;
        step();
        bi.fire_i = 1'b0;
    endtask

    task automatic do_reset();
        park();
        bi.fire_i = 1'b0;
        reset_ni  = 1'b0;
        step();
        step();
        reset_ni = 1'b1;
        step();
    endtask

    task automatic launch(input logic [9:0] tx, input logic [9:0] ty, input dir_e d);
        do_reset();
        bi.tank_x_i   = tx;
        bi.tank_y_i   = ty;
        bi.tank_dir_i = d;
        fire_pulse();
        frame();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{10'd192, 10'd320, UP,    1'b0, 10'd204, 10'd312};
        vecs[1] = '{10'd192, 10'd320, DOWN,  1'b0, 10'd204, 10'd352};
        vecs[2] = '{10'd192, 10'd320, LEFT,  1'b0, 10'd184, 10'd332};
        vecs[3] = '{10'd192, 10'd320, RIGHT, 1'b0, 10'd224, 10'd332};
        vecs[4] = '{10'd0,   10'd100, LEFT,  1'b1, 10'd0,   10'd0};
        vecs[5] = '{10'd100, 10'd4,   UP,    1'b1, 10'd0,   10'd0};
        vecs[6] = '{10'd8,   10'd8,   LEFT,  1'b0, 10'd0,   10'd20};
        vecs[7] = '{10'd8,   10'd8,   UP,    1'b0, 10'd20,  10'd0};

        bi.fire_i     = 1'b0;
        bi.tank_x_i   = 10'd0;
        bi.tank_y_i   = 10'd0;
        bi.tank_dir_i = UP;
        park();
        reset_ni = 1'b0;
        step();
        step();

        // reset state: nothing drawn even over the reset box at (0,0)
        drive_pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        check("rst_active",  {31'd0, bi.bullet_active_o},  32'd0);
        check("rst_explode", {31'd0, bi.exploding_o},      32'd0);
        check("rst_enable",  {31'd0, bi.bullet_enable_o},  32'd0);
        check("rst_collide", {31'd0, bi.bullet_collide_o}, 32'd0);
        check("rst_blue",    {24'd0, bi.bullet_blue_o},    32'd0);
        reset_ni = 1'b1;
        step();
        frame();
        check("rst_idle_after_tick", {31'd0, bi.bullet_active_o}, 32'd0);

        // spawn table
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].tx, vecs[i].ty, vecs[i].dir);
            check($sformatf("v%0d_active", i), {31'd0, bi.bullet_active_o}, {31'd0, !vecs[i].refused});
            if (vecs[i].refused) begin
                frame();
                check($sformatf("v%0d_still_idle", i), {31'd0, bi.bullet_active_o}, 32'd0);
            end else begin
                drive_pix(vecs[i].ex, vecs[i].ey, 1'b1, 1'b0, 1'b0);
                check($sformatf("v%0d_tl", i), {31'd0, bi.bullet_enable_o}, 32'd1);
                step();
                drive_pix(vecs[i].ex + 10'd7, vecs[i].ey + 10'd7, 1'b1, 1'b0, 1'b0);
                check($sformatf("v%0d_br", i), {31'd0, bi.bullet_enable_o}, 32'd1);
                step();
                drive_pix(vecs[i].ex + 10'd8, vecs[i].ey, 1'b1, 1'b0, 1'b0);
                check($sformatf("v%0d_right_out", i), {31'd0, bi.bullet_enable_o}, 32'd0);
                step();
                drive_pix(vecs[i].ex, vecs[i].ey + 10'd8, 1'b1, 1'b0, 1'b0);
                check($sformatf("v%0d_below_out", i), {31'd0, bi.bullet_enable_o}, 32'd0);
                step();
                if (vecs[i].ex != 10'd0) begin
                    drive_pix(vecs[i].ex - 10'd1, vecs[i].ey, 1'b1, 1'b0, 1'b0);
                    check($sformatf("v%0d_left_out", i), {31'd0, bi.bullet_enable_o}, 32'd0);
                    step();
                end
            end
        end

        // spawn up then one move: box at x 204..211, y 308..315
        launch(10'd192, 10'd320, UP);
        frame();
        begin
            int rows[4];
            rows = '{307, 308, 315, 316};
            foreach (rows[r]) begin
                for (int h = 203; h <= 212; h++) begin
                    logic exp_en;
                    exp_en = (rows[r] >= 308) && (rows[r] <= 315) && (h >= 204) && (h <= 211);
                    drive_pix(10'(h), 10'(rows[r]), 1'b1, 1'b0, 1'b0);
                    check($sformatf("mv_en_%0d_%0d", h, rows[r]), {31'd0, bi.bullet_enable_o}, {31'd0, exp_en});
                    check($sformatf("mv_blue_%0d_%0d", h, rows[r]), {24'd0, bi.bullet_blue_o}, exp_en ? 32'hFF : 32'h0);
                    step();
                end
            end
        end
        drive_pix(10'd205, 10'd310, 1'b1, 1'b0, 1'b0);
        check("mv_green", {24'd0, bi.bullet_green_o}, 32'hFF);
        check("mv_red",   {24'd0, bi.bullet_red_o},   32'hFF);
        step();

        // brick hit: bullet x 92..99 after five moves, brick at x 96..127
        launch(10'd40, 10'd200, RIGHT);
        repeat (5) frame();
        for (int h = 88; h <= 103; h++) begin
            logic brick;
            brick = (h >= 96) && (h <= 127);
            drive_pix(10'(h), 10'd212, 1'b1, brick, brick);
            check($sformatf("brick_col_%0d", h), {31'd0, bi.bullet_collide_o},
                  {31'd0, (h >= 96) && (h <= 99)});
            step();
        end
        drive_pix(10'd96, 10'd220, 1'b1, 1'b1, 1'b1);
        check("brick_col_below", {31'd0, bi.bullet_collide_o}, 32'd0);
        step();
        check("brick_fly_before_tick", {31'd0, bi.bullet_active_o}, 32'd1);
        frame();
        check("brick_exploding", {31'd0, bi.exploding_o},     32'd1);
        check("brick_not_active", {31'd0, bi.bullet_active_o}, 32'd0);
        drive_pix(10'd96, 10'd212, 1'b1, 1'b1, 1'b1);
        check("exp_enable", {31'd0, bi.bullet_enable_o},  32'd1);
        check("exp_collide", {31'd0, bi.bullet_collide_o}, 32'd0);
        step();
        fire_pulse();
        repeat (7) frame();
        check("exp_after7", {31'd0, bi.exploding_o}, 32'd1);
        frame();
        check("exp_after8", {31'd0, bi.exploding_o},     32'd0);
        check("exp_idle",   {31'd0, bi.bullet_active_o}, 32'd0);
        frame();
        check("exp_fire_ignored", {31'd0, bi.bullet_active_o}, 32'd0);

        // wall at the left field edge: hard but not destroyable
        launch(10'd8, 10'd300, LEFT);
        fire_pulse();
        for (int h = 0; h <= 15; h++) begin
            drive_pix(10'(h), 10'd312, 1'b1, 1'b1, 1'b0);
            check($sformatf("wall_col_%0d", h), {31'd0, bi.bullet_collide_o}, 32'd0);
            step();
        end
        frame();
        check("wall_exploding", {31'd0, bi.exploding_o}, 32'd1);
        repeat (8) frame();
        check("wall_done", {31'd0, bi.exploding_o}, 32'd0);
        frame();
        check("wall_fly_fire_ignored", {31'd0, bi.bullet_active_o}, 32'd0);

        // left move at x=0 without a hit leaves the field
        launch(10'd8, 10'd300, LEFT);
        check("edge_fly", {31'd0, bi.bullet_active_o}, 32'd1);
        fire_pulse();
        frame();
        check("edge_gone",    {31'd0, bi.bullet_active_o}, 32'd0);
        check("edge_no_expl", {31'd0, bi.exploding_o},     32'd0);
        frame();
        check("edge_fire_ignored", {31'd0, bi.bullet_active_o}, 32'd0);

        // hard pixel coincides with the tick pixel: box x 0..7, y 476..483
        launch(10'd8, 10'd464, LEFT);
        check("sim_fly", {31'd0, bi.bullet_active_o}, 32'd1);
        drive_pix(10'd0, 10'd480, 1'b1, 1'b1, 1'b0);
        step();
        park();
        #1;
        check("sim_exploding", {31'd0, bi.exploding_o}, 32'd1);
        drive_pix(10'd0, 10'd476, 1'b1, 1'b0, 1'b0);
        check("sim_no_move", {31'd0, bi.bullet_enable_o}, 32'd1);
        step();

        // reset mid-flight, box at (200,200)
        launch(10'd168, 10'd188, RIGHT);
        drive_pix(10'd200, 10'd200, 1'b1, 1'b0, 1'b1);
        check("mr_active",  {31'd0, bi.bullet_active_o},  32'd1);
        check("mr_collide", {31'd0, bi.bullet_collide_o}, 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("mr_rst_active",  {31'd0, bi.bullet_active_o},  32'd0);
        check("mr_rst_enable",  {31'd0, bi.bullet_enable_o},  32'd0);
        check("mr_rst_collide", {31'd0, bi.bullet_collide_o}, 32'd0);
        check("mr_rst_blue",    {24'd0, bi.bullet_blue_o},    32'd0);
        check("mr_rst_explode", {31'd0, bi.exploding_o},      32'd0);
        step();
        reset_ni = 1'b1;
        step();
        frame();
        check("mr_idle", {31'd0, bi.bullet_active_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
